// File: rtl/sum_block_accumulator_pkg.sv
// sum_block_accumulator_pkg: shared state encoding and default widths
// for the block accumulator.
package sum_block_accumulator_pkg;
   localparam int SUM_W = 9;
   localparam int ACC_W = 16;
   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;
endpackage

// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator: sums COUNT accepted samples into a block total with sticky overflow.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - synchronous abort of the partial block and any pending result
//   in_valid/in_ready   - sample handshake; in_ready is high only while accumulating
//   in_data             - unsigned IN_W-bit sample
//   out_valid/out_ready - result handshake; the result is held stable until it is taken
//   out_sum             - block total modulo 2^ACC_W
//   out_overflow        - a carry out of ACC_W occurred somewhere in the block
module sum_block_accumulator #(
   parameter int IN_W  = sum_block_accumulator_pkg::SUM_W,
   parameter int ACC_W = sum_block_accumulator_pkg::ACC_W,
   parameter int COUNT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_overflow
);
   import sum_block_accumulator_pkg::*;

   localparam int CW = $clog2(COUNT) + 1;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d, sovf_q, sovf_d;
   logic [ACC_W:0]   sum_ext;
   logic             accept, last;

   assign in_ready     = state_q == ST_ACCUM;
   assign out_valid    = state_q == ST_HOLD;
   assign out_sum      = sum_q;
   assign out_overflow = sovf_q;

   // One extra bit on the adder captures the carry out of ACC_W.
   assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
   assign accept  = in_valid && in_ready;
   assign last    = cnt_q == CW'(COUNT - 1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      sovf_d  = sovf_q;
      if (clear) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         sum_d   = '0;
         sovf_d  = 1'b0;
      end else if (accept) begin
         acc_d = sum_ext[ACC_W-1:0];
         ovf_d = ovf_q | sum_ext[ACC_W];
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            state_d = ST_HOLD;
            sum_d   = sum_ext[ACC_W-1:0];
            sovf_d  = ovf_q | sum_ext[ACC_W];
         end
      end else if (out_valid && out_ready) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         sovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         sovf_q  <= sovf_d;
      end
   end
endmodule
